target_ctl: RTL and testbench



---
 rtl/target_ctl.sv | 239 +++++++++++++++++++++++
 tb/tb_target_ctl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_ctl.sv
// Per-frame target sequencer: position, bounce, hit/fall/escape/respawn, score and miss counts.
// Define TARGET_CTL_LFSR_SPAWN_EN for pseudo-random spawn x/dx; otherwise spawns are centred with alternating dx.
module target_ctl #(
  parameter int H_RES         = 800,
  parameter int V_RES         = 600,
  parameter int TGT_W         = 50,
  parameter int TGT_H         = 50,
  parameter int SPEED         = 2,
  parameter int FALL_SPEED    = 4,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 300,
  parameter int MAX_MISS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        start,
  input  logic        hit,
  output logic [10:0] tgt_x,
  output logic [10:0] tgt_y,
  output logic        tgt_visible,
  output logic        tgt_hit,
  output logic [7:0]  score,
  output logic [1:0]  miss_cnt,
  output logic        game_over,
  output logic [2:0]  dbg_state
);

  localparam int XMAX = H_RES - TGT_W;
  localparam int YMAX = V_RES - TGT_H;
  localparam logic [10:0] XMAX_U = 11'(XMAX);
  localparam logic [10:0] YMAX_U = 11'(YMAX);
  localparam logic [10:0] X_HOME = 11'(XMAX / 2);
  localparam logic signed [11:0] XMAX_S  = 12'(XMAX);
  localparam logic signed [11:0] YMAX_S  = 12'(YMAX);
  localparam logic signed [11:0] SPEED_S = 12'(SPEED);
  localparam logic signed [11:0] FALL_S  = 12'(FALL_SPEED);
  localparam logic [8:0] HIT_LAST  = 9'(HIT_FRAMES - 1);
  localparam logic [8:0] ESC_LAST  = 9'(ESCAPE_FRAMES - 1);
  localparam logic [1:0] MISS_LAST = 2'(MAX_MISS - 1);
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;
  localparam logic [1:0] DIR_ZERO = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESPAWN = 3'd1,
    FLY     = 3'd2,
    HIT     = 3'd3,
    FALL    = 3'd4,
    ESCAPE  = 3'd5,
    OVER    = 3'd6
  } state_t;

  state_t      state;
  logic        vblnk_q;
  logic        frame_tick;
  logic [1:0]  dx;
  logic [1:0]  dy;
  logic [8:0]  frame_cnt;
  logic [10:0] spawn_x;
  logic [1:0]  spawn_dx;

  logic signed [11:0] x_cur, y_cur, x_mv, y_mv, y_fall, y_esc;

  assign dbg_state = state;

  function automatic logic [1:0] flip(input logic [1:0] d);
    return (d == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

  // Frame boundary: one-cycle pulse on the registered rising edge of vblnk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_q    <= vblnk;
      frame_tick <= vblnk & ~vblnk_q;
    end
  end

`ifdef TARGET_CTL_LFSR_SPAWN_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  always_comb begin
    spawn_x = {1'b0, lfsr[9:0]};
    if (spawn_x >= XMAX_U) spawn_x = spawn_x - 11'd512;
    spawn_dx = lfsr[10] ? DIR_NEG : DIR_POS;
  end
`else
  logic spawn_alt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 spawn_alt <= 1'b0;
    else if (state == RESPAWN)  spawn_alt <= ~spawn_alt;
  end

  always_comb begin
    spawn_x  = X_HOME;
    spawn_dx = spawn_alt ? DIR_NEG : DIR_POS;
  end
`endif

  // Candidate positions in signed 12-bit so under/overflow past the edges is visible.
  always_comb begin
    x_cur = $signed({1'b0, tgt_x});
    y_cur = $signed({1'b0, tgt_y});
    x_mv  = x_cur;
    y_mv  = y_cur;
    case (dx)
      DIR_POS: x_mv = x_cur + SPEED_S;
      DIR_NEG: x_mv = x_cur - SPEED_S;
      default: ;
    endcase
    case (dy)
      DIR_POS: y_mv = y_cur + SPEED_S;
      DIR_NEG: y_mv = y_cur - SPEED_S;
      default: ;
    endcase
    y_fall = y_cur + FALL_S;
    y_esc  = y_cur - SPEED_S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tgt_x       <= X_HOME;
      tgt_y       <= YMAX_U;
      dx          <= DIR_POS;
      dy          <= DIR_NEG;
      frame_cnt   <= '0;
      tgt_visible <= 1'b0;
      tgt_hit     <= 1'b0;
      score       <= '0;
      miss_cnt    <= '0;
      game_over   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RESPAWN;
        end
        RESPAWN: begin
          tgt_x       <= spawn_x;
          tgt_y       <= YMAX_U;
          dx          <= spawn_dx;
          dy          <= DIR_NEG;
          frame_cnt   <= '0;
          tgt_visible <= 1'b1;
          state       <= FLY;
        end
        FLY: begin
          // A hit beats a coincident frame_tick: the target freezes where it is.
          if (hit) begin
            frame_cnt <= '0;
            tgt_hit   <= 1'b1;
            state     <= HIT;
          end else if (frame_tick) begin
            if (x_mv < 12'sd0) begin
              tgt_x <= '0;
              dx    <= flip(dx);
            end else if (x_mv > XMAX_S) begin
              tgt_x <= XMAX_U;
              dx    <= flip(dx);
            end else begin
              tgt_x <= x_mv[10:0];
            end
            if (y_mv < 12'sd0) begin
              tgt_y <= '0;
              dy    <= flip(dy);
            end else if (y_mv > YMAX_S) begin
              tgt_y <= YMAX_U;
              dy    <= flip(dy);
            end else begin
              tgt_y <= y_mv[10:0];
            end
            frame_cnt <= frame_cnt + 9'd1;
            if (frame_cnt == ESC_LAST) begin
              dx    <= DIR_ZERO;
              state <= ESCAPE;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            frame_cnt <= frame_cnt + 9'd1;
            if (frame_cnt == HIT_LAST) state <= FALL;
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (y_fall >= YMAX_S) begin
              tgt_y       <= YMAX_U;
              tgt_visible <= 1'b0;
              tgt_hit     <= 1'b0;
              if (score != 8'hFF) score <= score + 8'd1;
              state       <= RESPAWN;
            end else begin
              tgt_y <= y_fall[10:0];
            end
          end
        end
        ESCAPE: begin
          if (frame_tick) begin
            if (y_esc <= 12'sd0) begin
              tgt_y       <= '0;
              tgt_visible <= 1'b0;
              miss_cnt    <= miss_cnt + 2'd1;
              if (miss_cnt == MISS_LAST) begin
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                state <= RESPAWN;
              end
            end else begin
              tgt_y <= y_esc[10:0];
            end
          end
        end
        OVER: begin
          if (start) begin
            score     <= '0;
            miss_cnt  <= '0;
            game_over <= 1'b0;
            state     <= RESPAWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_ctl.sv
// Bench for target_ctl: randomized frames/hits/starts checked against a frame-level behavioural model.
module tb_target_ctl;

  localparam int XMAX  = 750;
  localparam int YMAX  = 550;
  localparam int SPEED = 2;
  localparam int FALL  = 4;
  localparam int M_IDLE = 0, M_FLY = 1, M_HIT = 2, M_FALL = 3, M_ESC = 4, M_OVER = 5;

  logic        clk = 1'b0;
  logic        rst_n, vblnk, start, hit;
  logic [10:0] tgt_x, tgt_y;
  logic        tgt_visible, tgt_hit, game_over;
  logic [7:0]  score;
  logic [1:0]  miss_cnt;
  logic [2:0]  dbg_state;
  logic [34:0] obs_vec;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];

  int m_x, m_y, m_dx, m_dy, m_cnt, m_score, m_miss, m_mode;
  bit m_alt;
  logic [15:0] m_lfsr, m_lfsr_prev;

  target_ctl dut (
    .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start), .hit(hit),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_visible(tgt_visible), .tgt_hit(tgt_hit),
    .score(score), .miss_cnt(miss_cnt), .game_over(game_over), .dbg_state(dbg_state)
  );

  assign obs_vec = {tgt_x, tgt_y, tgt_visible, tgt_hit, score, miss_cnt, game_over};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // LFSR reference, kept one cycle of history: a spawn uses the value before its loading edge.
  always @(posedge clk or negedge rst_n) begin : lfsr_model
    int fb;
    if (!rst_n) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      fb = ((int'(m_lfsr) >> 0) ^ (int'(m_lfsr) >> 2) ^ (int'(m_lfsr) >> 3) ^ (int'(m_lfsr) >> 5)) & 1;
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= 16'((int'(m_lfsr) >> 1) | (fb << 15));
    end
  end

  // reference model
  function automatic void m_reset();
    m_x = XMAX / 2; m_y = YMAX; m_dx = 1; m_dy = -1;
    m_cnt = 0; m_score = 0; m_miss = 0; m_mode = M_IDLE; m_alt = 1'b0;
  endfunction

  function automatic void m_spawn();
`ifdef TARGET_CTL_LFSR_SPAWN_EN
    int v;
    logic [15:0] l;
    l = m_lfsr_prev;
    v = int'(l[9:0]);
    if (v >= XMAX) v = v - 512;
    m_x  = v;
    m_dx = l[10] ? -1 : 1;
`else
    m_x   = XMAX / 2;
    m_dx  = m_alt ? -1 : 1;
    m_alt = !m_alt;
`endif
    m_y = YMAX; m_dy = -1; m_cnt = 0; m_mode = M_FLY;
  endfunction

  function automatic void m_move();
    int nx, ny;
    nx = m_x + SPEED * m_dx;
    ny = m_y + SPEED * m_dy;
    if (nx < 0) begin m_x = 0; m_dx = -m_dx; end
    else if (nx > XMAX) begin m_x = XMAX; m_dx = -m_dx; end
    else m_x = nx;
    if (ny < 0) begin m_y = 0; m_dy = -m_dy; end
    else if (ny > YMAX) begin m_y = YMAX; m_dy = -m_dy; end
    else m_y = ny;
  endfunction

  function automatic void m_start();
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (m_mode == M_OVER) begin m_score = 0; m_miss = 0; end
      m_spawn();
    end
  endfunction

  function automatic void m_hit();
    if (m_mode == M_FLY) begin m_mode = M_HIT; m_cnt = 0; end
  endfunction

  function automatic void m_frame(input bit h, input bit s);
    if (s && (m_mode == M_IDLE || m_mode == M_OVER)) begin
      m_start();
      return;
    end
    case (m_mode)
      M_FLY: begin
        if (h) m_hit();
        else begin
          m_move();
          m_cnt++;
          if (m_cnt == 300) begin m_mode = M_ESC; m_dx = 0; end
        end
      end
      M_HIT: begin
        m_cnt++;
        if (m_cnt == 30) m_mode = M_FALL;
      end
      M_FALL: begin
        m_y = m_y + FALL;
        if (m_y >= YMAX) begin
          m_y = YMAX;
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_spawn();
        end
      end
      M_ESC: begin
        m_y = m_y - SPEED;
        if (m_y <= 0) begin
          m_y = 0;
          m_miss++;
          if (m_miss == 3) m_mode = M_OVER;
          else m_spawn();
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [34:0] exp_vec();
    logic vis, hv, ov;
    vis = (m_mode == M_FLY) || (m_mode == M_HIT) || (m_mode == M_FALL) || (m_mode == M_ESC);
    hv  = (m_mode == M_HIT) || (m_mode == M_FALL);
    ov  = (m_mode == M_OVER);
    return {11'(m_x), 11'(m_y), vis, hv, 8'(m_score), 2'(m_miss), ov};
  endfunction

  // driver tasks (entered and left on a falling edge)
  task automatic drv_tick(input bit h, input bit s);
    vblnk = 1'b1;
    @(negedge clk);
    hit = h; start = s;
    @(negedge clk);
    hit = 1'b0; start = 1'b0; vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic drv_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic drv_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; vblnk = 1'b0; start = 1'b0; hit = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    total++;
    if (obs_vec !== {11'd375, 11'd550, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs_vec, {11'd375, 11'd550, 28'd0} >> 15);
    end
    rst_n = 1'b1;
    @(negedge clk);
    drv_hit(); m_hit();
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL idle_hit got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
  endtask

  task automatic test_start();
    drv_start(); m_start();
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL start_spawn got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
`ifndef TARGET_CTL_LFSR_SPAWN_EN
    total++;
    if (tgt_x !== 11'd375 || tgt_y !== 11'd550 || tgt_visible !== 1'b1) begin
      bad++; $display("FAIL spawn_pos got x=%0d y=%0d vis=%0b want x=375 y=550 vis=1", tgt_x, tgt_y, tgt_visible);
    end
`endif
    drv_tick(0, 0); m_frame(0, 0);
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL first_tick got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
`ifndef TARGET_CTL_LFSR_SPAWN_EN
    total++;
    if (tgt_x !== 11'd377 || tgt_y !== 11'd548) begin
      bad++; $display("FAIL first_move got x=%0d y=%0d want x=377 y=548", tgt_x, tgt_y);
    end
`endif
  endtask

  task automatic test_bounce();
    for (int i = 2; i <= 189; i++) begin
      drv_tick(0, 0); m_frame(0, 0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL bounce_tick%0d got=%h want=%h st=%0d", i, obs_vec, exp_vec(), dbg_state);
      end
`ifndef TARGET_CTL_LFSR_SPAWN_EN
      if (i == 188) begin
        total++;
        if (tgt_x !== 11'd750) begin bad++; $display("FAIL right_edge got x=%0d want x=750", tgt_x); end
      end
      if (i == 189) begin
        total++;
        if (tgt_x !== 11'd748) begin bad++; $display("FAIL right_rebound got x=%0d want x=748", tgt_x); end
      end
`endif
    end
  endtask

  task automatic test_hit_fall();
    int px, py;
    repeat ($urandom_range(1, 10)) begin drv_tick(0, 0); m_frame(0, 0); end
    px = m_x; py = m_y;
    drv_tick(1, 0); m_frame(1, 0);
    total++;
    if (tgt_x !== 11'(px) || tgt_y !== 11'(py) || tgt_hit !== 1'b1) begin
      bad++; $display("FAIL hit_on_tick got x=%0d y=%0d hit=%0b want x=%0d y=%0d hit=1", tgt_x, tgt_y, tgt_hit, px, py);
    end
    for (int k = 0; k < 300 && m_mode != M_FLY; k++) begin
      drv_tick(0, 0); m_frame(0, 0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL hit_fall_tick%0d got=%h want=%h st=%0d", k, obs_vec, exp_vec(), dbg_state);
      end
    end
    total++;
    if (score !== 8'd1) begin bad++; $display("FAIL score_after_fall got %0d want 1", score); end
  endtask

  task automatic test_escape();
    for (int e = 1; e <= 3; e++) begin
      for (int j = 0; j < 700 && m_miss < e; j++) begin
        drv_tick(0, 0); m_frame(0, 0);
        total++;
        if (obs_vec !== exp_vec()) begin
          bad++; $display("FAIL escape%0d_tick%0d got=%h want=%h st=%0d", e, j, obs_vec, exp_vec(), dbg_state);
        end
      end
    end
    total++;
    if (game_over !== 1'b1 || tgt_visible !== 1'b0 || miss_cnt !== 2'd3) begin
      bad++; $display("FAIL game_over got over=%0b vis=%0b miss=%0d want over=1 vis=0 miss=3", game_over, tgt_visible, miss_cnt);
    end
    drv_start(); m_start();
    total++;
    if (score !== 8'd0 || miss_cnt !== 2'd0 || tgt_visible !== 1'b1 || game_over !== 1'b0) begin
      bad++; $display("FAIL restart got score=%0d miss=%0d vis=%0b over=%0b want 0 0 1 0", score, miss_cnt, tgt_visible, game_over);
    end
  endtask

  task automatic test_random();
    logic [34:0] want;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      case (r)
        0:       begin drv_start();    m_start();       end
        1:       begin drv_hit();      m_hit();         end
        2:       begin drv_tick(1, 0); m_frame(1, 0);   end
        3:       begin drv_tick(0, 1); m_frame(0, 1);   end
        default: begin drv_tick(0, 0); m_frame(0, 0);   end
      endcase
      exp_q.push_back(exp_vec());
      want = exp_q.pop_front();
      total++;
      if (obs_vec !== want) begin
        bad++; $display("FAIL random_step%0d op=%0d got=%h want=%h st=%0d", i, r, obs_vec, want, dbg_state);
      end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 1000 && m_mode != M_FLY; k++) begin
      if (m_mode == M_IDLE || m_mode == M_OVER) begin drv_start(); m_start(); end
      else begin drv_tick(0, 0); m_frame(0, 0); end
    end
    for (int s = 0; s < 256; s++) begin
      drv_hit(); m_hit();
      for (int t = 0; t < 200 && m_mode != M_FLY; t++) begin drv_tick(0, 0); m_frame(0, 0); end
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL shootdown%0d got=%h want=%h st=%0d", s, obs_vec, exp_vec(), dbg_state);
      end
    end
    total++;
    if (score !== 8'd255) begin bad++; $display("FAIL score_saturate got %0d want 255", score); end
  endtask

  task automatic test_reset_mid_fall();
    drv_hit(); m_hit();
    repeat (30) begin drv_tick(0, 0); m_frame(0, 0); end
    total++;
    if (obs_vec !== exp_vec() || m_mode != M_FALL) begin
      bad++; $display("FAIL enter_fall got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL async_reset got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drv_hit(); m_hit();
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL idle_hit_after_reset got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
    drv_start(); m_start();
    drv_tick(0, 0); m_frame(0, 0);
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL respawn_after_reset got=%h want=%h st=%0d", obs_vec, exp_vec(), dbg_state);
    end
`ifndef TARGET_CTL_LFSR_SPAWN_EN
    total++;
    if (tgt_x !== 11'd377) begin bad++; $display("FAIL dx_after_reset got x=%0d want x=377", tgt_x); end
`endif
  endtask

`ifdef TARGET_CTL_LFSR_SPAWN_EN
  task automatic test_lfsr_spawn();
    for (int n = 0; n < 40; n++) begin
      drv_hit(); m_hit();
      for (int t = 0; t < 200 && m_mode != M_FLY; t++) begin drv_tick(0, 0); m_frame(0, 0); end
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL lfsr_spawn%0d got=%h want=%h st=%0d", n, obs_vec, exp_vec(), dbg_state);
      end
      total++;
      if (tgt_x > 11'd750) begin bad++; $display("FAIL lfsr_range%0d got x=%0d want x<=750", n, tgt_x); end
      drv_tick(0, 0); m_frame(0, 0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL lfsr_dir%0d got=%h want=%h st=%0d", n, obs_vec, exp_vec(), dbg_state);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_hit_fall();
    test_escape();
    test_random();
    test_saturate();
    test_reset_mid_fall();
`ifdef TARGET_CTL_LFSR_SPAWN_EN
    test_lfsr_spawn();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
